// File: rtl/prog_counter_unit.sv
// Program counter for the RAT MCU fetch path with a built-in return-address stack
// that serves CALL, RET and interrupt entry without touching scratch RAM.
module prog_counter_unit #(
  parameter int         STACK_DEPTH = 8,
  parameter logic [9:0] RESET_ADDR  = 10'h000,
  parameter logic [9:0] INTR_ADDR   = 10'h3FF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PC_INC,
  input  logic       PC_LD,
  input  logic [1:0] PC_MUX_SEL,
  input  logic [9:0] IMMED,
  input  logic       STK_PUSH,
  input  logic       STK_POP,
  output logic [9:0] PC_COUNT,
  output logic [9:0] TOS,
  output logic       STK_EMPTY,
  output logic       STK_FULL,
  output logic       STK_ERR
);

  localparam int            AW         = $clog2(STACK_DEPTH);
  localparam int            DW         = AW + 1;
  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);
  localparam logic [DW-1:0] ONE        = DW'(1);

  logic [9:0]    pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [9:0]    stk_q [STACK_DEPTH];
  logic [9:0]    stk_d [STACK_DEPTH];

  logic          empty;
  logic          full;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] next_idx;
  logic [9:0]    tos;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == FULL_DEPTH);
  assign top_idx  = AW'(depth_q - ONE);
  assign next_idx = depth_q[AW-1:0];
  // An empty stack reads as zero, which is also what a RET on underflow loads.
  assign tos      = empty ? 10'h000 : stk_q[top_idx];

  always_comb begin
    pc_d = pc_q;
    if (PC_LD) begin
      case (PC_MUX_SEL)
        2'd0:    pc_d = IMMED;
        2'd1:    pc_d = tos;
        2'd2:    pc_d = INTR_ADDR;
        default: pc_d = pc_q;
      endcase
    end else if (PC_INC) begin
      pc_d = pc_q + 10'd1;
    end
  end

  always_comb begin
    stk_d   = stk_q;
    depth_d = depth_q;
    err_d   = err_q;
    if (STK_PUSH && STK_POP) begin
      // Replace the top in place; on an empty stack this degenerates to a plain push.
      if (empty) begin
        stk_d[next_idx] = pc_q;
        depth_d         = depth_q + ONE;
      end else begin
        stk_d[top_idx] = pc_q;
      end
    end else if (STK_PUSH) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        stk_d[next_idx] = pc_q;
        depth_d         = depth_q + ONE;
      end
    end else if (STK_POP) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        depth_d = depth_q - ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      stk_q   <= stk_d;
    end
  end

  assign PC_COUNT  = pc_q;
  assign TOS       = tos;
  assign STK_EMPTY = empty;
  assign STK_FULL  = full;
  assign STK_ERR   = err_q;

endmodule
